fetch_unit: RTL and testbench

Instruction-fetch stage of the 32-bit pipelined processor. Holds the program counter, requests instructions from instruction memory over a ready handshake, and drives the IF/ID pipeline register. That register's opcode field feeds the control unit. The block consumes the control unit's `MuxDireccionPC` redirect select and the hazard unit's stall, and flushes IF/ID with a NOP on every taken jump or branch.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ready-handshaked imem request, IF/ID register with NOP flush on redirect.
// One-cycle accept-to-IF/ID latency; a word accepted under stall is parked in a skid register.
module fetch_unit #(
   parameter int                  ADDR_W    = 32,
   parameter int                  INSTR_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'hB800_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          MuxDireccionPC,
   input  logic [ADDR_W-1:0]   jump_target,
   input  logic [ADDR_W-1:0]   branch_target,
   input  logic                stall,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_ready,
   output logic [INSTR_W-1:0]  ifid_instr,
   output logic [ADDR_W-1:0]   ifid_pc,
   output logic                ifid_valid,
   output logic [4:0]          Opcode
);

   typedef enum logic {S_FETCH, S_HELD} state_t;

   state_t               r_state;
   logic [ADDR_W-1:0]    r_pc;
   logic [ADDR_W-1:0]    r_skid_pc;
   logic [INSTR_W-1:0]   r_skid_instr;
   logic [INSTR_W-1:0]   r_ifid_instr;
   logic [ADDR_W-1:0]    r_ifid_pc;
   logic                 r_ifid_valid;
   logic                 r_imem_req;

   logic                 w_redirect;
   logic [ADDR_W-1:0]    w_target;
   logic [ADDR_W-1:0]    w_pc_inc;

   // Select 11 is neither jump nor branch, so it falls through as sequential.
   assign w_redirect = (MuxDireccionPC == 2'b01) || (MuxDireccionPC == 2'b10);
   assign w_target   = (MuxDireccionPC == 2'b10) ? branch_target : jump_target;
   assign w_pc_inc   = r_pc + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_pc    <= '0;
         r_ifid_valid <= 1'b0;
         r_imem_req   <= 1'b1;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_redirect) begin
                  r_pc         <= w_target;
                  r_ifid_instr <= NOP_INSTR;
                  r_ifid_pc    <= '0;
                  r_ifid_valid <= 1'b0;
               end else if (imem_ready && !stall) begin
                  r_ifid_instr <= imem_rdata;
                  r_ifid_pc    <= r_pc;
                  r_ifid_valid <= 1'b1;
                  r_pc         <= w_pc_inc;
               end else if (imem_ready) begin
                  // Word arrived while decode is stalled: park it and stop requesting.
                  r_skid_instr <= imem_rdata;
                  r_skid_pc    <= r_pc;
                  r_pc         <= w_pc_inc;
                  r_state      <= S_HELD;
                  r_imem_req   <= 1'b0;
               end
            end
            S_HELD: begin
               if (w_redirect) begin
                  r_pc         <= w_target;
                  r_ifid_instr <= NOP_INSTR;
                  r_ifid_pc    <= '0;
                  r_ifid_valid <= 1'b0;
                  r_skid_instr <= '0;
                  r_skid_pc    <= '0;
                  r_state      <= S_FETCH;
                  r_imem_req   <= 1'b1;
               end else if (!stall) begin
                  r_ifid_instr <= r_skid_instr;
                  r_ifid_pc    <= r_skid_pc;
                  r_ifid_valid <= 1'b1;
                  r_state      <= S_FETCH;
                  r_imem_req   <= 1'b1;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_req   = r_imem_req;
   assign imem_addr  = r_pc;
   assign ifid_instr = r_ifid_instr;
   assign ifid_pc    = r_ifid_pc;
   assign ifid_valid = r_ifid_valid;
   assign Opcode     = r_ifid_instr[INSTR_W-1 -: 5];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr+0x100 combinationally.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  MuxDireccionPC;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic        ifid_valid;
   logic [4:0]  Opcode;

   int n_vec  = 0;
   int n_miss = 0;

   localparam logic [31:0] NOP = 32'hB800_0000;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .MuxDireccionPC (MuxDireccionPC),
      .jump_target    (jump_target),
      .branch_target  (branch_target),
      .stall          (stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .ifid_valid     (ifid_valid),
      .Opcode         (Opcode)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr + 32'h100;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic vld);
      chk({tag, ".instr"}, 64'(ifid_instr), 64'(instr));
      chk({tag, ".pc"},    64'(ifid_pc),    64'(pc));
      chk({tag, ".valid"}, 64'(ifid_valid), 64'(vld));
   endtask

   initial begin
      reset = 1'b1; MuxDireccionPC = 2'b00; jump_target = 32'h0;
      branch_target = 32'h0; stall = 1'b0; imem_ready = 1'b1;
      step(); step();
      chk_ifid("rst", NOP, 32'h0, 1'b0);
      chk("rst.opcode", 64'(Opcode), 64'(5'b10111));
      reset = 1'b0;
      #1;
      chk("first.req",  64'(imem_req),  64'd1);
      chk("first.addr", 64'(imem_addr), 64'd0);
      chk("first.opcode", 64'(Opcode), 64'(5'b10111));

      // free run
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid("run", 32'h100 + 32'(i), 32'(i), 1'b1);
         chk("run.addr", 64'(imem_addr), 64'(i + 1));
      end

      // two wait states at addr 3
      imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("wait.addr", 64'(imem_addr), 64'd3);
         chk("wait.ifid", 64'(ifid_instr), 64'h102);
      end
      imem_ready = 1'b1;
      #1;
      chk("wait.addr3rd", 64'(imem_addr), 64'd3);
      step();
      chk_ifid("wait.acc", 32'h103, 32'd3, 1'b1);
      chk("wait.next", 64'(imem_addr), 64'd4);
      step();
      chk_ifid("seq4", 32'h104, 32'd4, 1'b1);

      // stall at accept of PC=5, held 3 cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("held.req", 64'(imem_req), 64'd0);
         chk("held.ifid", 64'(ifid_instr), 64'h104);
         chk("held.addr", 64'(imem_addr), 64'd6);
      end
      stall = 1'b0;
      step();
      chk_ifid("unstall", 32'h105, 32'd5, 1'b1);
      chk("unstall.req", 64'(imem_req), 64'd1);
      chk("unstall.addr", 64'(imem_addr), 64'd6);
      step();
      chk_ifid("resume", 32'h106, 32'd6, 1'b1);
      chk("resume.addr", 64'(imem_addr), 64'd7);

      // jump at PC=7
      MuxDireccionPC = 2'b01; jump_target = 32'h40; branch_target = 32'h77;
      step();
      chk("jmp.addr", 64'(imem_addr), 64'h40);
      chk_ifid("jmp.bubble", NOP, 32'h0, 1'b0);
      chk("jmp.opcode", 64'(Opcode), 64'(5'b10111));
      MuxDireccionPC = 2'b00;
      step();
      chk_ifid("jmp.tgt", 32'h140, 32'h40, 1'b1);
      chk("jmp.next", 64'(imem_addr), 64'h41);

      // branch while in HELD
      stall = 1'b1;
      step();
      chk("br.held.req", 64'(imem_req), 64'd0);
      MuxDireccionPC = 2'b10; branch_target = 32'h20; jump_target = 32'h99;
      step();
      chk("br.addr", 64'(imem_addr), 64'h20);
      chk("br.req", 64'(imem_req), 64'd1);
      chk_ifid("br.bubble", NOP, 32'h0, 1'b0);
      MuxDireccionPC = 2'b00; stall = 1'b0;
      step();
      chk_ifid("br.tgt", 32'h120, 32'h20, 1'b1);
      MuxDireccionPC = 2'b11;
      step();
      chk_ifid("sel11", 32'h121, 32'h21, 1'b1);
      chk("sel11.addr", 64'(imem_addr), 64'h22);

      // wrap at top of address space
      MuxDireccionPC = 2'b01; jump_target = 32'hFFFF_FFFF;
      step();
      chk("wrap.at", 64'(imem_addr), 64'hFFFF_FFFF);
      MuxDireccionPC = 2'b00;
      step();
      chk_ifid("wrap.acc", 32'h0000_00FF, 32'hFFFF_FFFF, 1'b1);
      chk("wrap.addr", 64'(imem_addr), 64'h0);

      // reset while HELD
      stall = 1'b1;
      step();
      chk("rst2.held", 64'(imem_req), 64'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk_ifid("rst2", NOP, 32'h0, 1'b0);
      chk("rst2.req", 64'(imem_req), 64'd1);
      chk("rst2.addr", 64'(imem_addr), 64'd0);
      chk("rst2.opcode", 64'(Opcode), 64'(5'b10111));
      stall = 1'b0;
      step();
      chk_ifid("rst2.run", 32'h100, 32'h0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
